// File: rtl/bg_req_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : bg_req_ctrl
//  Purpose  : Burst request controller for one 8-bank SRAM bank group, with
//             bank-interleaved addressing and a small read response FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module bg_req_ctrl #(
   parameter int DW        = 256,
   parameter int NB        = 8,
   parameter int RW        = 7,
   parameter int AW        = 10,
   parameter int LW        = 4,
   parameter int RSP_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wr,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [LW-1:0]    cmd_len,
   input  logic             wd_valid,
   output logic             wd_ready,
   input  logic [DW-1:0]    wd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_data,
   output logic             rsp_last,
   output logic             done,
   output logic [NB-1:0]    bg_en_n,
   output logic [NB-1:0]    bg_wen_n,
   output logic [RW-1:0]    bg_addr,
   output logic [DW-1:0]    bg_din,
   input  logic [NB*DW-1:0] bg_dout
);

   localparam int c_bw = $clog2(NB);
   localparam int c_pw = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int c_cw = $clog2(RSP_DEPTH + 1);
   localparam logic [c_cw:0]   c_depth = (c_cw+1)'(RSP_DEPTH);
   localparam logic [c_pw-1:0] c_last_ptr = c_pw'(RSP_DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } state_t;

   state_t            r_state;
   logic [AW-1:0]     r_cur_addr;
   logic [LW-1:0]     r_beats_left;
   logic              r_done;
   logic              r_inflight;
   logic [c_bw-1:0]   r_rd_bank;
   logic              r_rd_last;

   logic [DW-1:0]     r_fifo_data [RSP_DEPTH];
   logic              r_fifo_last [RSP_DEPTH];
   logic [c_pw-1:0]   r_wptr;
   logic [c_pw-1:0]   r_rptr;
   logic [c_cw-1:0]   r_count;

   logic [c_bw-1:0]   w_bank;
   logic [RW-1:0]     w_row;
   logic              w_cmd_fire;
   logic              w_wr_beat;
   logic              w_pop;
   logic              w_push;
   logic [c_cw:0]     w_occ;
   logic              w_issue;
   logic              w_access;
   logic              w_step;
   logic              w_final;
   logic [NB-1:0]     w_onehot;
   logic [DW-1:0]     w_rd_word;

   assign w_bank     = r_cur_addr[c_bw-1:0];
   assign w_row      = r_cur_addr[AW-1:c_bw];
   assign cmd_ready  = (r_state == S_IDLE) && !rst;
   assign wd_ready   = (r_state == S_WR) && !rst;
   assign w_cmd_fire = cmd_valid && cmd_ready;
   assign w_wr_beat  = wd_valid && wd_ready;
   assign w_pop      = rsp_valid && rsp_ready;
   assign w_push     = r_inflight;

   // Slots already committed: stored beats plus the one in flight, minus a departing beat.
   assign w_occ    = {1'b0, r_count} + {{c_cw{1'b0}}, r_inflight} - {{c_cw{1'b0}}, w_pop};
   assign w_issue  = (r_state == S_RD) && !rst && (w_occ < c_depth);
   assign w_access = w_wr_beat || w_issue;
   assign w_step   = w_access;
   assign w_final  = w_step && (r_beats_left == '0);
   assign w_onehot = {{(NB-1){1'b0}}, 1'b1} << w_bank;

   assign bg_en_n  = w_access  ? ~w_onehot : '1;
   assign bg_wen_n = w_wr_beat ? ~w_onehot : '1;
   assign bg_addr  = w_access  ? w_row     : '0;
   assign bg_din   = w_wr_beat ? wd_data   : '0;

   assign w_rd_word = bg_dout[int'(r_rd_bank)*DW +: DW];

   assign rsp_valid = (r_count != '0);
   assign rsp_data  = r_fifo_data[r_rptr];
   assign rsp_last  = r_fifo_last[r_rptr];
   assign done      = r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cur_addr   <= '0;
         r_beats_left <= '0;
         r_done       <= 1'b0;
         r_inflight   <= 1'b0;
         r_rd_bank    <= '0;
         r_rd_last    <= 1'b0;
      end else begin
         r_done     <= w_final;
         r_inflight <= w_issue;
         if (w_issue) begin
            r_rd_bank <= w_bank;
            r_rd_last <= (r_beats_left == '0);
         end
         case (r_state)
            S_IDLE: begin
               if (w_cmd_fire) begin
                  r_cur_addr   <= cmd_addr;
                  r_beats_left <= cmd_len;
                  r_state      <= cmd_wr ? S_WR : S_RD;
               end
            end
            S_WR, S_RD: begin
               if (w_step) begin
                  r_cur_addr   <= r_cur_addr + 1'b1;
                  r_beats_left <= r_beats_left - 1'b1;
                  if (r_beats_left == '0) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Capture the bank word one cycle after issue, once the SRAM has sampled it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wptr] <= w_rd_word;
            r_fifo_last[r_wptr] <= r_rd_last;
            r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
         end
         r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bg_req_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bg_req_ctrl
//  Purpose  : Self-checking bench for bg_req_ctrl with a behavioural bank model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bg_req_ctrl;

   localparam int DW = 256, NB = 8, RW = 7, AW = 10, LW = 4, RSP_DEPTH = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid, cmd_ready, cmd_wr;
   logic [AW-1:0]    cmd_addr;
   logic [LW-1:0]    cmd_len;
   logic             wd_valid, wd_ready;
   logic [DW-1:0]    wd_data;
   logic             rsp_valid, rsp_ready, rsp_last, done;
   logic [DW-1:0]    rsp_data;
   logic [NB-1:0]    bg_en_n, bg_wen_n;
   logic [RW-1:0]    bg_addr;
   logic [DW-1:0]    bg_din;
   logic [NB*DW-1:0] bg_dout;

   logic [DW-1:0]    mem [NB][1<<RW];
   rsp_t             exp_q[$];
   int               checks = 0;
   int               errors = 0;

   bg_req_ctrl #(.DW(DW), .NB(NB), .RW(RW), .AW(AW), .LW(LW), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .done(done),
      .bg_en_n(bg_en_n), .bg_wen_n(bg_wen_n), .bg_addr(bg_addr), .bg_din(bg_din),
      .bg_dout(bg_dout)
   );

   always #5 clk = ~clk;

   // Single-port synchronous SRAM per bank: read data appears after the sampling edge.
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (!bg_en_n[b]) begin
            if (!bg_wen_n[b]) mem[b][bg_addr] <= bg_din;
            else              bg_dout[b*DW +: DW] <= mem[b][bg_addr];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input int len, input int base);
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = addr; cmd_len = LW'(len);
      step();
      cmd_valid = 1'b0;
      wd_valid  = 1'b1;
      for (int i = 0; i <= len; i++) begin
         wd_data = DW'(base + i);
         step();
      end
      wd_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         step();
         #1;
         checks++;
         if (bg_en_n !== 8'hFF || bg_wen_n !== 8'hFF || bg_addr !== '0) begin
            errors++;
            $display("FAIL reset_bank en_n=%h wen_n=%h addr=%0d required FF FF 0", bg_en_n, bg_wen_n, bg_addr);
         end
         checks++;
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || wd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl rsp_valid=%b cmd_ready=%b wd_ready=%b done=%b required 0 0 0 0",
                     rsp_valid, cmd_ready, wd_ready, done);
         end
      end
      rst = 1'b0;
      step();
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || bg_en_n !== 8'hFF) begin
         errors++;
         $display("FAIL reset_release cmd_ready=%b en_n=%h required 1 FF", cmd_ready, bg_en_n);
      end
   endtask

   task automatic test_write_burst();
      logic [AW-1:0] a;
      logic [NB-1:0] exp_en;
      int            pulses;
      pulses = 0;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h005; cmd_len = 4'd3;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_cmd_ready got=%b required 1", cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wd_valid = 1'b1;
         wd_data  = DW'(32'hA + i);
         #1;
         a      = 10'h005 + AW'(i);
         exp_en = ~(8'b1 << a[2:0]);
         if (done === 1'b1) pulses++;
         checks++;
         if (wd_ready !== 1'b1 || bg_en_n !== exp_en || bg_wen_n !== exp_en) begin
            errors++;
            $display("FAIL wr_beat%0d_bank wd_ready=%b en_n=%h wen_n=%h required 1 %h %h",
                     i, wd_ready, bg_en_n, bg_wen_n, exp_en, exp_en);
         end
         checks++;
         if (bg_addr !== a[9:3] || bg_din !== DW'(10 + i)) begin
            errors++;
            $display("FAIL wr_beat%0d_data addr=%0d din=%h required %0d %h", i, bg_addr, bg_din, a[9:3], 10 + i);
         end
         step();
      end
      wd_valid = 1'b0;
      #1;
      checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b1 || bg_en_n !== 8'hFF) begin
         errors++;
         $display("FAIL wr_done done=%b cmd_ready=%b en_n=%h required 1 1 FF", done, cmd_ready, bg_en_n);
      end
      step();
      #1;
      checks++;
      if (done !== 1'b0 || pulses != 0) begin
         errors++;
         $display("FAIL wr_done_once done=%b early_pulses=%0d required 0 0", done, pulses);
      end
   endtask

   task automatic test_read_back();
      rsp_t e, g;
      for (int i = 0; i < 4; i++) begin
         e.data = DW'(32'hA + i);
         e.last = (i == 3);
         exp_q.push_back(e);
      end
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h005; cmd_len = 4'd3; rsp_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++;
         if (rsp_valid !== (c >= 2 && c <= 5) || done !== (c == 4)) begin
            errors++;
            $display("FAIL rd_timing cycle=%0d rsp_valid=%b done=%b required %b %b",
                     c, rsp_valid, done, (c >= 2 && c <= 5), (c == 4));
         end
         if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g.data = rsp_data; g.last = rsp_last;
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL rd_data data=%h last=%b required %h %b", g.data, g.last, e.data, e.last);
            end
         end
         step();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_count remaining=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_backpressure();
      rsp_t          e, g;
      int            issued, got;
      logic          have_held;
      logic [DW-1:0] held_data;
      logic          held_last;
      issued = 0; got = 0; have_held = 1'b0; held_data = '0; held_last = 1'b0;
      do_write(10'h040, 7, 32'h100);
      for (int i = 0; i < 8; i++) begin
         e.data = DW'(32'h100 + i);
         e.last = (i == 7);
         exp_q.push_back(e);
      end
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h040; cmd_len = 4'd7; rsp_ready = 1'b0;
      step();
      cmd_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (bg_en_n !== 8'hFF) issued++;
         if (rsp_valid === 1'b1) begin
            if (have_held) begin
               checks++;
               if (rsp_data !== held_data || rsp_last !== held_last) begin
                  errors++;
                  $display("FAIL bp_stable cycle=%0d data=%h last=%b required %h %b",
                           c, rsp_data, rsp_last, held_data, held_last);
               end
            end else begin
               have_held = 1'b1;
               held_data = rsp_data;
               held_last = rsp_last;
            end
         end
         step();
      end
      checks++;
      if (issued != 2 || !have_held || held_data !== exp_q[0].data) begin
         errors++;
         $display("FAIL bp_stall issued=%0d valid_seen=%b head=%h required 2 1 %h",
                  issued, have_held, held_data, exp_q[0].data);
      end
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         #1;
         if (bg_en_n !== 8'hFF) issued++;
         if (rsp_valid === 1'b1) begin
            e = exp_q.pop_front();
            g.data = rsp_data; g.last = rsp_last;
            got++;
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL bp_data beat=%0d data=%h last=%b required %h %b", got - 1, g.data, g.last, e.data, e.last);
            end
         end
         step();
      end
      repeat (3) step();
      #1;
      checks++;
      if (got != 8 || issued != 8 || exp_q.size() != 0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_total beats=%0d issued=%0d left=%0d rsp_valid=%b required 8 8 0 0",
                  got, issued, exp_q.size(), rsp_valid);
         exp_q.delete();
      end
   endtask

   task automatic test_wrap();
      logic [NB-1:0] en_tab [2];
      logic [RW-1:0] row_tab [2];
      en_tab[0] = 8'h7F; en_tab[1] = 8'hFE;
      row_tab[0] = 7'd127; row_tab[1] = 7'd0;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h3FF; cmd_len = 4'd1;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wd_valid = 1'b1;
         wd_data  = DW'(32'h55 + i);
         #1;
         checks++;
         if (bg_en_n !== en_tab[i] || bg_wen_n !== en_tab[i] || bg_addr !== row_tab[i]) begin
            errors++;
            $display("FAIL wrap_beat%0d en_n=%h wen_n=%h addr=%0d required %h %h %0d",
                     i, bg_en_n, bg_wen_n, bg_addr, en_tab[i], en_tab[i], row_tab[i]);
         end
         step();
      end
      wd_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_read();
      rsp_t e, g;
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h040; cmd_len = 4'd15; rsp_ready = 1'b0;
      step();
      cmd_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      checks++;
      if (bg_en_n !== 8'hFF || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_same_cycle en_n=%h cmd_ready=%b required FF 0", bg_en_n, cmd_ready);
      end
      step();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (bg_en_n !== 8'hFF || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle cycle=%0d en_n=%h rsp_valid=%b cmd_ready=%b required FF 0 1",
                     c, bg_en_n, rsp_valid, cmd_ready);
         end
         step();
      end
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h010; cmd_len = 4'd0;
      step();
      cmd_valid = 1'b0;
      wd_valid  = 1'b1;
      wd_data   = DW'(32'h77);
      #1;
      checks++;
      if (bg_en_n !== 8'hFE || bg_wen_n !== 8'hFE || bg_addr !== 7'd2) begin
         errors++;
         $display("FAIL rstmid_new_cmd en_n=%h wen_n=%h addr=%0d required FE FE 2", bg_en_n, bg_wen_n, bg_addr);
      end
      step();
      wd_valid = 1'b0;
      e.data = DW'(32'h77); e.last = 1'b1;
      exp_q.push_back(e);
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h010; cmd_len = 4'd0; rsp_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g.data = rsp_data; g.last = rsp_last;
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL rstmid_readback data=%h last=%b required %h %b", g.data, g.last, e.data, e.last);
            end
         end
         step();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rstmid_readback_missing remaining=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
      wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b0;
      test_reset();
      test_write_burst();
      test_read_back();
      test_backpressure();
      test_wrap();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
